// File: rtl/store_lane_aligner.sv
// Store/load lane aligner: turns one right-justified LSU request into one or two
// line-aligned bus beats with per-byte enables and lane-shifted data.
module store_lane_aligner #(
    parameter int BUS_BYTES = 16,
    parameter int ADDR_W    = 32,
    localparam int LOG_BB   = $clog2(BUS_BYTES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [2:0]               req_size,
    input  logic                     req_write,
    input  logic [8*BUS_BYTES-1:0]   req_wdata,
    output logic                     bus_valid,
    input  logic                     bus_ready,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [BUS_BYTES-1:0]     bus_be,
    output logic [8*BUS_BYTES-1:0]   bus_wdata,
    output logic                     bus_write,
    output logic                     bus_last,
    output logic                     bus_split,
    output logic                     err_size
);

    localparam int DW = 8 * BUS_BYTES;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;

    logic [1:0]              state_reg, state_next;
    logic                    valid_reg, valid_next;
    logic [ADDR_W-1:0]       addr_reg, addr_next;
    logic [BUS_BYTES-1:0]    be_reg, be_next;
    logic [BUS_BYTES-1:0]    be_hi_reg, be_hi_next;
    logic [DW-1:0]           wdata_reg, wdata_next;
    logic [DW-1:0]           wdata_hi_reg, wdata_hi_next;
    logic                    write_reg, write_next;
    logic                    last_reg, last_next;
    logic                    split_reg, split_next;
    logic                    err_reg, err_next;

    logic                    accept;
    logic [31:0]             n_bytes;
    logic                    size_legal;
    logic [LOG_BB-1:0]       off;
    logic [BUS_BYTES-1:0]    lane_keep;
    logic [DW-1:0]           wdata_masked;
    logic [2*BUS_BYTES-1:0]  mask2;
    logic [2*DW-1:0]         data2;
    logic                    split;
    logic [ADDR_W-1:0]       line_addr;

    assign req_ready  = (state_reg == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign n_bytes    = 32'd1 << req_size;
    assign size_legal = n_bytes <= 32'(BUS_BYTES);
    assign off        = req_addr[LOG_BB-1:0];
    assign line_addr  = {req_addr[ADDR_W-1:LOG_BB], {LOG_BB{1'b0}}};

    // Keep only the low n bytes of the request; anything above is forced to zero.
    genvar gi;
    generate
        for (gi = 0; gi < BUS_BYTES; gi++) begin : g_lane
            assign lane_keep[gi] = 32'(gi) < n_bytes;
            assign wdata_masked[8*gi +: 8] = lane_keep[gi] ? req_wdata[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign mask2 = {{BUS_BYTES{1'b0}}, lane_keep} << off;
    assign data2 = {{DW{1'b0}}, wdata_masked} << {off, 3'b000};
    assign split = (32'(off) + n_bytes) > 32'(BUS_BYTES);

    always_comb begin
        state_next    = state_reg;
        valid_next    = valid_reg;
        addr_next     = addr_reg;
        be_next       = be_reg;
        be_hi_next    = be_hi_reg;
        wdata_next    = wdata_reg;
        wdata_hi_next = wdata_hi_reg;
        write_next    = write_reg;
        last_next     = last_reg;
        split_next    = split_reg;
        err_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (!size_legal) begin
                        err_next = 1'b1;
                    end else begin
                        state_next    = BEAT0;
                        valid_next    = 1'b1;
                        addr_next     = line_addr;
                        be_next       = mask2[BUS_BYTES-1:0];
                        be_hi_next    = mask2[2*BUS_BYTES-1:BUS_BYTES];
                        wdata_next    = data2[DW-1:0];
                        wdata_hi_next = data2[2*DW-1:DW];
                        write_next    = req_write;
                        last_next     = !split;
                        split_next    = split;
                    end
                end
            end
            BEAT0: begin
                if (bus_ready) begin
                    if (split_reg) begin
                        state_next = BEAT1;
                        addr_next  = addr_reg + ADDR_W'(BUS_BYTES);
                        be_next    = be_hi_reg;
                        wdata_next = wdata_hi_reg;
                        last_next  = 1'b1;
                    end else begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                    end
                end
            end
            BEAT1: begin
                if (bus_ready) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            valid_reg    <= 1'b0;
            addr_reg     <= '0;
            be_reg       <= '0;
            be_hi_reg    <= '0;
            wdata_reg    <= '0;
            wdata_hi_reg <= '0;
            write_reg    <= 1'b0;
            last_reg     <= 1'b0;
            split_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            valid_reg    <= valid_next;
            addr_reg     <= addr_next;
            be_reg       <= be_next;
            be_hi_reg    <= be_hi_next;
            wdata_reg    <= wdata_next;
            wdata_hi_reg <= wdata_hi_next;
            write_reg    <= write_next;
            last_reg     <= last_next;
            split_reg    <= split_next;
            err_reg      <= err_next;
        end
    end

    assign bus_valid = valid_reg;
    assign bus_addr  = addr_reg;
    assign bus_be    = be_reg;
    assign bus_wdata = wdata_reg;
    assign bus_write = write_reg;
    assign bus_last  = last_reg;
    assign bus_split = split_reg;
    assign err_size  = err_reg;

endmodule

// File: tb/tb_store_lane_aligner.sv
// Directed bench for store_lane_aligner (BUS_BYTES=16, ADDR_W=32): each task drives
// one scenario and compares outputs against hand-computed constants.
module tb_store_lane_aligner;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic [2:0]   req_size;
    logic         req_write;
    logic [127:0] req_wdata;
    logic         bus_valid;
    logic         bus_ready;
    logic [31:0]  bus_addr;
    logic [15:0]  bus_be;
    logic [127:0] bus_wdata;
    logic         bus_write;
    logic         bus_last;
    logic         bus_split;
    logic         err_size;

    int n_cmp;
    int n_fail;

    store_lane_aligner #(.BUS_BYTES(16), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_write(req_write), .req_wdata(req_wdata),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_write(bus_write),
        .bus_last(bus_last), .bus_split(bus_split), .err_size(err_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick();
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_cmp++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus_valid); end
        n_cmp++; if ({bus_addr, bus_be, bus_write, bus_last, bus_split, err_size} !== 52'h0) begin n_fail++; $display("FAIL reset_outs: got %h/%h/%b%b%b%b want 0", bus_addr, bus_be, bus_write, bus_last, bus_split, err_size); end
        n_cmp++; if (bus_wdata !== 128'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus_wdata); end
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
        $display("reset: done");
    endtask

    task automatic test_byte_store;
        req_valid = 1'b1; req_addr = 32'h1003; req_size = 3'd0; req_write = 1'b1;
        req_wdata = 128'hCD_AB;
        tick();
        req_valid = 1'b0;
        n_cmp++; if (bus_valid !== 1'b1) begin n_fail++; $display("FAIL byte_valid: got %b want 1", bus_valid); end
        n_cmp++; if (bus_addr !== 32'h1000) begin n_fail++; $display("FAIL byte_addr: got %h want 00001000", bus_addr); end
        n_cmp++; if (bus_be !== 16'h0008) begin n_fail++; $display("FAIL byte_be: got %h want 0008", bus_be); end
        n_cmp++; if (bus_wdata !== 128'hAB00_0000) begin n_fail++; $display("FAIL byte_wdata: got %h want ab000000", bus_wdata); end
        n_cmp++; if ({bus_last, bus_split, bus_write} !== 3'b101) begin n_fail++; $display("FAIL byte_flags: got %b%b%b want 101", bus_last, bus_split, bus_write); end
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL byte_busy_ready: got %b want 0", req_ready); end
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        n_cmp++; if ({bus_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL byte_done: got valid=%b ready=%b want 0/1", bus_valid, req_ready); end
        $display("byte store addr=00001003: be=%h", 16'h0008);
    endtask

    task automatic test_word_split_hold;
        req_valid = 1'b1; req_addr = 32'h200E; req_size = 3'd2; req_write = 1'b1;
        req_wdata = 128'h99_1122_3344;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({bus_valid, bus_addr, bus_be} !== {1'b1, 32'h2000, 16'hC000}) begin n_fail++; $display("FAIL word_beat0_%0d: got v=%b a=%h be=%h want 1/00002000/c000", i, bus_valid, bus_addr, bus_be); end
            n_cmp++; if (bus_wdata !== {16'h3344, 112'h0}) begin n_fail++; $display("FAIL word_beat0_data_%0d: got %h want 3344<<112", i, bus_wdata); end
            n_cmp++; if ({bus_last, bus_split} !== 2'b01) begin n_fail++; $display("FAIL word_beat0_flags_%0d: got %b%b want 01", i, bus_last, bus_split); end
            if (i < 3) tick();
        end
        bus_ready = 1'b1;
        tick();
        n_cmp++; if ({bus_valid, bus_addr, bus_be} !== {1'b1, 32'h2010, 16'h0003}) begin n_fail++; $display("FAIL word_beat1: got v=%b a=%h be=%h want 1/00002010/0003", bus_valid, bus_addr, bus_be); end
        n_cmp++; if (bus_wdata !== 128'h1122) begin n_fail++; $display("FAIL word_beat1_data: got %h want 1122", bus_wdata); end
        n_cmp++; if ({bus_last, bus_split} !== 2'b11) begin n_fail++; $display("FAIL word_beat1_flags: got %b%b want 11", bus_last, bus_split); end
        tick();
        bus_ready = 1'b0;
        n_cmp++; if ({bus_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL word_done: got valid=%b ready=%b want 0/1", bus_valid, req_ready); end
        $display("word store addr=0000200e: split into 2 beats");
    endtask

    task automatic test_quad;
        req_valid = 1'b1; req_addr = 32'h3000; req_size = 3'd4; req_write = 1'b1;
        req_wdata = {16{8'h5A}};
        tick();
        req_valid = 1'b0;
        n_cmp++; if ({bus_valid, bus_be, bus_last, bus_split} !== {1'b1, 16'hFFFF, 2'b10}) begin n_fail++; $display("FAIL quad_aligned: got v=%b be=%h l=%b s=%b want 1/ffff/1/0", bus_valid, bus_be, bus_last, bus_split); end
        n_cmp++; if (bus_wdata !== {16{8'h5A}}) begin n_fail++; $display("FAIL quad_aligned_data: got %h want 5a..5a", bus_wdata); end
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h3001;
        tick();
        req_valid = 1'b0;
        n_cmp++; if ({bus_valid, bus_addr, bus_be, bus_last, bus_split} !== {1'b1, 32'h3000, 16'hFFFE, 2'b01}) begin n_fail++; $display("FAIL quad_mis_beat0: got v=%b a=%h be=%h l=%b s=%b want 1/00003000/fffe/0/1", bus_valid, bus_addr, bus_be, bus_last, bus_split); end
        n_cmp++; if (bus_wdata !== {{15{8'h5A}}, 8'h00}) begin n_fail++; $display("FAIL quad_mis_data0: got %h want 5a..5a00", bus_wdata); end
        bus_ready = 1'b1;
        tick();
        n_cmp++; if ({bus_valid, bus_addr, bus_be, bus_last} !== {1'b1, 32'h3010, 16'h0001, 1'b1}) begin n_fail++; $display("FAIL quad_mis_beat1: got v=%b a=%h be=%h l=%b want 1/00003010/0001/1", bus_valid, bus_addr, bus_be, bus_last); end
        n_cmp++; if (bus_wdata !== 128'h5A) begin n_fail++; $display("FAIL quad_mis_data1: got %h want 5a", bus_wdata); end
        tick();
        bus_ready = 1'b0;
        $display("quad store addr=00003000 and 00003001: done");
    endtask

    task automatic test_load;
        req_valid = 1'b1; req_addr = 32'h6006; req_size = 3'd2; req_write = 1'b0;
        req_wdata = 128'h0102_0304;
        tick();
        req_valid = 1'b0;
        n_cmp++; if ({bus_valid, bus_addr, bus_be, bus_write} !== {1'b1, 32'h6000, 16'h03C0, 1'b0}) begin n_fail++; $display("FAIL load_beat: got v=%b a=%h be=%h w=%b want 1/00006000/03c0/0", bus_valid, bus_addr, bus_be, bus_write); end
        n_cmp++; if (bus_wdata !== 128'h0102_0304_0000_0000_0000) begin n_fail++; $display("FAIL load_data: got %h want 01020304<<48", bus_wdata); end
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        $display("word load addr=00006006: be=%h", 16'h03C0);
    endtask

    task automatic test_err_size;
        req_valid = 1'b1; req_addr = 32'h7000; req_size = 3'd5; req_write = 1'b1;
        tick();
        req_valid = 1'b0;
        n_cmp++; if ({err_size, bus_valid, req_ready} !== 3'b101) begin n_fail++; $display("FAIL err_pulse: got err=%b v=%b rdy=%b want 1/0/1", err_size, bus_valid, req_ready); end
        tick();
        n_cmp++; if ({err_size, bus_valid, req_ready} !== 3'b001) begin n_fail++; $display("FAIL err_clear: got err=%b v=%b rdy=%b want 0/0/1", err_size, bus_valid, req_ready); end
        $display("illegal size 5: err pulse");
    endtask

    task automatic test_wrap_and_reset;
        req_valid = 1'b1; req_addr = 32'hFFFF_FFFE; req_size = 3'd2; req_write = 1'b1;
        req_wdata = 128'hDEAD_BEEF;
        tick();
        req_valid = 1'b0;
        n_cmp++; if ({bus_addr, bus_be, bus_split} !== {32'hFFFF_FFF0, 16'hC000, 1'b1}) begin n_fail++; $display("FAIL wrap_beat0: got a=%h be=%h s=%b want fffffff0/c000/1", bus_addr, bus_be, bus_split); end
        bus_ready = 1'b1;
        tick();
        n_cmp++; if ({bus_valid, bus_addr, bus_be} !== {1'b1, 32'h0, 16'h0003}) begin n_fail++; $display("FAIL wrap_beat1: got v=%b a=%h be=%h want 1/00000000/0003", bus_valid, bus_addr, bus_be); end
        n_cmp++; if (bus_wdata !== 128'hDEAD) begin n_fail++; $display("FAIL wrap_data1: got %h want dead", bus_wdata); end
        tick();
        bus_ready = 1'b0;
        $display("split store addr=fffffffe: wrapped");
        req_valid = 1'b1; req_addr = 32'h400F; req_size = 3'd1;
        tick();
        req_valid = 1'b0;
        n_cmp++; if ({bus_valid, bus_split} !== 2'b11) begin n_fail++; $display("FAIL rst_pre: got v=%b s=%b want 1/1", bus_valid, bus_split); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if ({bus_valid, req_ready, bus_be, bus_split} !== {2'b01, 16'h0, 1'b0}) begin n_fail++; $display("FAIL rst_mid: got v=%b rdy=%b be=%h s=%b want 0/1/0000/0", bus_valid, req_ready, bus_be, bus_split); end
        bus_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_beat1_%0d: got %b want 0", i, bus_valid); end
        end
        bus_ready = 1'b0;
        $display("split store addr=0000400f: dropped by reset");
    endtask

    task automatic test_back_to_back;
        int accepts;
        bus_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h5000; req_size = 3'd2; req_write = 1'b1;
        req_wdata = 128'h1;
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            if (req_ready) accepts++;
            n_cmp++; if ((req_ready && bus_valid) !== 1'b0) begin n_fail++; $display("FAIL b2b_overlap_%0d: got ready&valid=1 want 0", i); end
            tick();
        end
        n_cmp++; if (accepts !== 4) begin n_fail++; $display("FAIL b2b_unsplit_rate: got %0d want 4", accepts); end
        $display("back-to-back unsplit: %0d accepts in 8 cycles", accepts);
        req_addr = 32'h500E;
        accepts = 0;
        for (int i = 0; i < 9; i++) begin
            if (req_ready) accepts++;
            n_cmp++; if ((req_ready && bus_valid) !== 1'b0) begin n_fail++; $display("FAIL b2b_split_overlap_%0d: got ready&valid=1 want 0", i); end
            tick();
        end
        n_cmp++; if (accepts !== 3) begin n_fail++; $display("FAIL b2b_split_rate: got %0d want 3", accepts); end
        $display("back-to-back split: %0d accepts in 9 cycles", accepts);
        req_valid = 1'b0;
        tick();
        bus_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_size = '0;
        req_write = 1'b0;
        req_wdata = '0;
        bus_ready = 1'b0;
        test_reset();
        test_byte_store();
        test_word_split_hold();
        test_quad();
        test_load();
        test_err_size();
        test_wrap_and_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
